// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator with 1 bpp framebuffer scanout.
// Stage 0 holds the h/v timing counters and the fb_x/fb_y scaling counters,
// stage 1 registers the VRAM address and region/sync flags, and stage 2
// registers the final colour, data-enable and syncs. All state advances on
// timer_vga_tick only.
module vga_scanout #(
   parameter int          H_ACTIVE     = 640,
   parameter int          H_FP         = 16,
   parameter int          H_SYNC       = 96,
   parameter int          H_BP         = 48,
   parameter int          V_ACTIVE     = 480,
   parameter int          V_FP         = 10,
   parameter int          V_SYNC       = 2,
   parameter int          V_BP         = 33,
   parameter logic        HSYNC_POL    = 1'b0,
   parameter logic        VSYNC_POL    = 1'b0,
   parameter int          FB_W         = 64,
   parameter int          FB_H         = 32,
   parameter int          SCALE_X      = 10,
   parameter int          SCALE_Y      = 15,
   parameter int unsigned VRAM_BASE    = 32'h100,
   parameter int          ADDR_W       = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              timer_vga_tick,
   input  logic              enable,
   input  logic [11:0]       fg_color,
   input  logic [11:0]       bg_color,
   input  logic [11:0]       border_color,
   output logic [ADDR_W-1:0] memory_addr,
   input  logic [7:0]        memory_data,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              vga_de,
   output logic              vblank,
   output logic              frame_start
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int VW        = $clog2(V_TOTAL);
   localparam int IMG_W     = FB_W * SCALE_X;
   localparam int IMG_H     = FB_H * SCALE_Y;
   localparam int X0        = (H_ACTIVE - IMG_W) / 2;
   localparam int Y0        = (V_ACTIVE - IMG_H) / 2;
   localparam int FXW       = $clog2(FB_W + 1);
   localparam int FYW       = $clog2(FB_H + 1);
   localparam int SXW       = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int SYW       = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
   localparam int ROW_BYTES = FB_W / 8;

   localparam logic [HW-1:0]  L_H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]  L_V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0]  L_H_ACT   = HW'(H_ACTIVE);
   localparam logic [VW-1:0]  L_V_ACT   = VW'(V_ACTIVE);
   localparam logic [HW-1:0]  L_X0      = HW'(X0);
   localparam logic [VW-1:0]  L_Y0      = VW'(Y0);
   localparam logic [HW-1:0]  L_X0_M1   = HW'((X0 > 0) ? X0 - 1 : 0);
   localparam logic [VW-1:0]  L_Y0_M1   = VW'((Y0 > 0) ? Y0 - 1 : 0);
   localparam logic [HW-1:0]  L_IMG_W   = HW'(IMG_W);
   localparam logic [VW-1:0]  L_IMG_H   = VW'(IMG_H);
   localparam logic [HW-1:0]  L_HS0     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  L_HSW     = HW'(H_SYNC);
   localparam logic [VW-1:0]  L_VS0     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  L_VSW     = VW'(V_SYNC);
   localparam logic [SXW-1:0] L_SX_LAST = SXW'(SCALE_X - 1);
   localparam logic [SYW-1:0] L_SY_LAST = SYW'(SCALE_Y - 1);

   generate
      if (IMG_W > H_ACTIVE || IMG_H > V_ACTIVE) begin : g_size_check
         $error("vga_scanout: scaled framebuffer does not fit the active area");
      end
   endgenerate

   // stage 0 state
   logic [HW-1:0]  r_h;
   logic [VW-1:0]  r_v;
   logic [SXW-1:0] r_xsub;
   logic [SYW-1:0] r_ysub;
   logic [FXW-1:0] r_fbx;
   logic [FYW-1:0] r_fby;

   // stage 1 state
   logic           r1_active;
   logic           r1_in_img;
   logic           r1_hs;
   logic           r1_vs;
   logic [2:0]     r1_bit;

   logic              w_h_wrap;
   logic              w_v_wrap;
   logic [HW-1:0]     w_hx;
   logic [VW-1:0]     w_vy;
   logic              w_in_x;
   logic              w_in_y;
   logic              w_in_img;
   logic              w_active;
   logic              w_hs_raw;
   logic              w_vs_raw;
   logic              w_x_clr;
   logic              w_y_clr;
   logic [ADDR_W-1:0] w_addr;
   logic              w_pixel;
   logic [11:0]       w_color;

   assign w_h_wrap = (r_h == L_H_LAST);
   assign w_v_wrap = (r_v == L_V_LAST);

   // Window tests use a wrapping subtract so a zero origin needs no special case.
   assign w_hx     = r_h - L_X0;
   assign w_vy     = r_v - L_Y0;
   assign w_in_x   = (w_hx < L_IMG_W);
   assign w_in_y   = (w_vy < L_IMG_H);
   assign w_in_img = w_in_x & w_in_y;
   assign w_active = (r_h < L_H_ACT) & (r_v < L_V_ACT);
   assign w_hs_raw = ((r_h - L_HS0) < L_HSW);
   assign w_vs_raw = ((r_v - L_VS0) < L_VSW);

   // Scaling counters are cleared on the tick that moves stage 0 onto the window origin.
   assign w_x_clr  = (X0 > 0) ? (r_h == L_X0_M1) : w_h_wrap;
   assign w_y_clr  = (Y0 > 0) ? (r_v == L_Y0_M1) : w_v_wrap;

   assign w_addr   = ADDR_W'(VRAM_BASE) + ADDR_W'(r_fby * ROW_BYTES) + ADDR_W'(r_fbx >> 3);

   assign vblank      = (r_v >= L_V_ACT);
   assign frame_start = reset_n & timer_vga_tick & (r_h == '0) & (r_v == '0);

   // Stage 0: timing counters and integer upscale counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h    <= '0;
         r_v    <= '0;
         r_xsub <= '0;
         r_ysub <= '0;
         r_fbx  <= '0;
         r_fby  <= '0;
      end else if (timer_vga_tick) begin
         r_h <= w_h_wrap ? '0 : r_h + HW'(1);
         if (w_h_wrap) begin
            r_v <= w_v_wrap ? '0 : r_v + VW'(1);
         end

         if (w_x_clr) begin
            r_xsub <= '0;
            r_fbx  <= '0;
         end else if (w_in_x) begin
            if (r_xsub == L_SX_LAST) begin
               r_xsub <= '0;
               r_fbx  <= r_fbx + FXW'(1);
            end else begin
               r_xsub <= r_xsub + SXW'(1);
            end
         end

         if (w_h_wrap) begin
            if (w_y_clr) begin
               r_ysub <= '0;
               r_fby  <= '0;
            end else if (w_in_y) begin
               if (r_ysub == L_SY_LAST) begin
                  r_ysub <= '0;
                  r_fby  <= r_fby + FYW'(1);
               end else begin
                  r_ysub <= r_ysub + SYW'(1);
               end
            end
         end
      end
   end

   // Stage 1: VRAM address, bit index, region flags and raw syncs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         memory_addr <= ADDR_W'(VRAM_BASE);
         r1_bit      <= '0;
         r1_active   <= 1'b0;
         r1_in_img   <= 1'b0;
         r1_hs       <= 1'b0;
         r1_vs       <= 1'b0;
      end else if (timer_vga_tick) begin
         if (w_in_img) begin
            memory_addr <= w_addr;
         end
         r1_bit    <= 3'd7 - r_fbx[2:0];
         r1_active <= w_active;
         r1_in_img <= w_in_img;
         r1_hs     <= w_hs_raw;
         r1_vs     <= w_vs_raw;
      end
   end

   assign w_pixel = memory_data[r1_bit];

   // Colour select for the pixel leaving stage 1.
   always_comb begin
      w_color = '0;
      if (enable && r1_active) begin
         if (r1_in_img) begin
            w_color = w_pixel ? fg_color : bg_color;
         end else begin
            w_color = border_color;
         end
      end
   end

   // Stage 2: output registers; syncs ignore enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_de                <= 1'b0;
         vga_hsync             <= ~HSYNC_POL;
         vga_vsync             <= ~VSYNC_POL;
      end else if (timer_vga_tick) begin
         {vga_r, vga_g, vga_b} <= w_color;
         vga_de                <= r1_active & enable;
         vga_hsync             <= r1_hs ^ ~HSYNC_POL;
         vga_vsync             <= r1_vs ^ ~VSYNC_POL;
      end
   end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Parametrised successor to the fixed 640x480 CHIP-8 VGA generator.
- Produces VGA timing from a pixel-rate enable and scans a 1 bpp, MSB-first, byte-packed framebuffer out of VRAM.
- Applies integer X/Y upscaling with counters instead of dividers, centres the image with a border colour, and aligns sync, data-enable and colour through a fixed 2-tick pipeline.
- Sits between the VRAM read port and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of vga_hsync
VSYNC_POL, 0, asserted level of vga_vsync
FB_W, 64, framebuffer width in pixels; multiple of 8
FB_H, 32, framebuffer height in pixels
SCALE_X, 10, horizontal upscale factor (>=1)
SCALE_Y, 15, vertical upscale factor (>=1)
VRAM_BASE, 12'h100, byte address of framebuffer row 0, byte 0
ADDR_W, 12, memory address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
timer_vga_tick  in  1  pixel enable, one clk wide; never asserted on two consecutive clks
enable  in  1  sampled on tick; 0 = outputs blanked, counters still run
fg_color  in  12  RGB444 colour for set pixels
bg_color  in  12  RGB444 colour for clear pixels
border_color  in  12  RGB444 colour for active area outside the image
memory_addr  out  ADDR_W  VRAM byte address
memory_data  in  8  VRAM read data; valid 1 clk after memory_addr changes
vga_r / vga_g / vga_b  out  4 each  colour
vga_hsync  out  1  horizontal sync
vga_vsync  out  1  vertical sync
vga_de  out  1  active-video flag
vblank  out  1  high while stage-0 line counter >= V_ACTIVE
frame_start  out  1  one-clk pulse on the tick where stage 0 is at h=0, v=0

Behaviour:
- Reset (async assert, sync release): h/v counters, all sub-counters and fb_x/fb_y = 0; memory_addr = VRAM_BASE; colour = 0; vga_de = 0; vblank = 0; frame_start = 0; syncs at their deasserted level (~POL).
- All state advances only on clk edges where timer_vga_tick = 1. Between ticks every output holds, except frame_start, which returns to 0.
- Stage 0 counters:
  - h_count wraps at H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_count increments on h wrap and wraps at V_TOTAL-1 (same construction).
  - Counter width is $clog2 of the total.
- Image window:
  - X0 = (H_ACTIVE - FB_W*SCALE_X)/2 and Y0 = (V_ACTIVE - FB_H*SCALE_Y)/2, both floored.
  - Elaboration fails (error) if FB_W*SCALE_X > H_ACTIVE or FB_H*SCALE_Y > V_ACTIVE.
- Scaling, X direction:
  - x_sub counts 0..SCALE_X-1 while h_count is inside the window.
  - fb_x increments when x_sub wraps.
  - Both clear when h_count = X0-1, or on h wrap when X0 = 0.
- Scaling, Y direction:
  - y_sub and fb_y behave the same way, stepping once per line at h wrap.
  - They clear at the start of line Y0.
- Stage 1, on tick:
  - Register memory_addr = VRAM_BASE + fb_y*(FB_W/8) + fb_x[..:3], truncated to ADDR_W.
  - Register bit index 7 - fb_x[2:0], plus region flags: active, in_image.
  - Register raw hsync and vsync. hsync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same form in lines.
  - Outside the image, memory_addr holds its last value.
- Stage 2, on tick:
  - Select pixel = memory_data[bit index].
  - Colour = !enable or !active → 0; active && !in_image → border_color; otherwise pixel ? fg_color : bg_color.
  - vga_de = active & enable.
  - Syncs are output XOR ~POL. Syncs are never gated by enable.
- Latency: colour, vga_de and the syncs trail stage-0 h_count by exactly 2 ticks. The sync-to-pixel relationship is identical to a zero-latency generator.
- vblank and frame_start are stage-0 signals and are not delayed.
- enable deasserted mid-line blanks from the next stage-2 update. Timing is never disturbed.
- Reset mid-frame restarts at h=0, v=0 with outputs at reset values.

Test Plan:
1. Default params, 2 full frames, tick every 4th clk → 800x525 ticks per frame; hsync low for 96 ticks starting at h=656 (+2 pipeline); vsync low on lines 490-491; frame_start once per 420000 ticks.
2. VRAM byte at 12'h100 = 8'b1000_0001, fg=12'hFFF, bg=12'h000 → output pixels x 0-9 and x 70-79 white, x 10-69 black, on lines 0-14 only.
3. FB_W=64, FB_H=32, SCALE_X=8, SCALE_Y=8 → X0=64, Y0=112; border_color on x<64, x>=576, y<112, y>=368; first fetch addr 12'h100 at line 112.
4. Last pixel (63,31) at default scale → memory_addr = 12'h1FF; line 479 pixel 639 shows bit 0 of 12'h1FF.
5. Drop enable at h=300 on line 100 → colour 0 and vga_de=0 from the next stage-2 update; syncs unchanged.
6. Assert reset_n=0 asynchronously mid-line → outputs reset immediately without a clk edge; after release, the first frame_start comes on the first tick.
